// File: rtl/sync_fifo_param_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_param_if
//
// Bundles the producer/consumer handshake of sync_fifo_param.
//   master : the side that uses the FIFO (drives writes, reads, clr_err)
//   slave  : the FIFO itself (drives read data, count, status and error flags)
//
// Signals
//   data_in      DATA_W    write data
//   wr_en        1         write request
//   rd_en        1         read request (acknowledge in FWFT mode)
//   clr_err      1         clears the sticky overflow/underflow flags
//   data_out     DATA_W    read data
//   rd_valid     1         data_out holds a newly read word
//   fifo_counter ADDR_W+1  number of stored words, 0..2**ADDR_W
//   full, empty, almost_full, almost_empty, overflow, underflow  status
// ---------------------------------------------------------------------------
interface sync_fifo_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
);
    logic [DATA_W-1:0] data_in;
    logic              wr_en;
    logic              rd_en;
    logic              clr_err;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic [ADDR_W:0]   fifo_counter;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output data_in, wr_en, rd_en, clr_err,
        input  data_out, rd_valid, fifo_counter, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  data_in, wr_en, rd_en, clr_err,
        output data_out, rd_valid, fifo_counter, full, empty,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//
// Parametrised single-clock FIFO with full/empty, programmable almost-full /
// almost-empty flags and sticky overflow/underflow error flags.
//
// Parameters
//   DATA_W     word width
//   ADDR_W     pointer width, depth is 2**ADDR_W
//   AF_THRESH  almost_full  when count >= AF_THRESH
//   AE_THRESH  almost_empty when count <= AE_THRESH
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous active-high reset; clears pointers, count, output
//          register and error flags (memory contents are not cleared)
//   bus    sync_fifo_param_if.slave, see the interface file for signal list
//
// Build option
//   FIFO_FWFT_EN  when defined, data_out shows the head word combinationally
//                 and rd_valid = !empty; rd_en acknowledges the head word.
//                 Otherwise reads are registered with one cycle of latency.
// ---------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned AF_THRESH = (2 ** ADDR_W) - 4,
    parameter int unsigned AE_THRESH = 4
) (
    input  logic             clk,
    input  logic             reset,
    sync_fifo_param_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_CNT    = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0]   AE_CNT    = (ADDR_W + 1)'(AE_THRESH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    // Storage; deliberately has no reset.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic full;
    logic empty;
    logic rd_acc;
    logic wr_acc;

    // Status flags decode the registered count only.
    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);

    // A read only needs data present. A write at full is still taken when a
    // read frees a slot in the same cycle. At empty there is no bypass: the
    // read is rejected and only the write is taken.
    assign rd_acc = bus.rd_en && !empty;
    assign wr_acc = bus.wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Error flags are sticky; a new error in the same cycle as clr_err wins.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (bus.wr_en && !wr_acc) begin
            overflow_d = 1'b1;
        end else if (bus.clr_err) begin
            overflow_d = 1'b0;
        end

        if (bus.rd_en && !rd_acc) begin
            underflow_d = 1'b1;
        end else if (bus.clr_err) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= bus.data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented as soon as it exists; when empty the output
    // simply shows whatever the head location last held.
    assign bus.data_out = mem[rd_ptr_q];
    assign bus.rd_valid = !empty;
`else
    logic [DATA_W-1:0] data_out_q;
    logic              rd_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                data_out_q <= mem[rd_ptr_q];
            end
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
`endif

    assign bus.fifo_counter = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AF_CNT);
    assign bus.almost_empty = (count_q <= AE_CNT);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (standard registered mode).
// Stimulus pushes expected read words into exp_q; a negedge monitor pops and
// compares them whenever rd_valid is high.
module tb_sync_fifo_param;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned AF     = 60;
    localparam int unsigned AE     = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sync_fifo_param #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    bit         m_ov;
    bit         m_un;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance before the edge.
    task automatic cycle(input bit wr, input logic [7:0] din, input bit rd, input bit clr);
        bit ra;
        bit wa;
        int n;
        ra = rd && (model_q.size() != 0);
        wa = wr && ((model_q.size() < DEPTH) || ra);
        if (ra) exp_q.push_back(model_q.pop_front());
        if (wa) model_q.push_back(din);
        if (wr && !wa) m_ov = 1'b1;
        else if (clr) m_ov = 1'b0;
        if (rd && !ra) m_un = 1'b1;
        else if (clr) m_un = 1'b0;

        bus.wr_en   = wr;
        bus.data_in = din;
        bus.rd_en   = rd;
        bus.clr_err = clr;
        @(posedge clk);
        #1;
        n = model_q.size();
        check("count", bus.fifo_counter, n);
        check("full", bus.full, n == DEPTH);
        check("empty", bus.empty, n == 0);
        check("almost_full", bus.almost_full, n >= AF);
        check("almost_empty", bus.almost_empty, n <= AE);
        check("overflow", bus.overflow, m_ov);
        check("underflow", bus.underflow, m_un);
        check("rd_valid", bus.rd_valid, ra);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL read_unexpected: got rd_valid with data 0x%0h, expected no read at %0t",
                         bus.data_out, $time);
            end else begin
                check("read_data", bus.data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        bus.data_in = '0;
        m_ov        = 1'b0;
        m_un        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", bus.fifo_counter, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_almost_empty", bus.almost_empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_almost_full", bus.almost_full, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_underflow", bus.underflow, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_data_out", bus.data_out, 0);
        reset = 1'b0;

        // Idle after reset: nothing changes.
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("idle_empty", bus.empty, 1);

        // Fill 0..63 and watch the threshold crossings.
        for (int k = 0; k < 64; k++) begin
            cycle(1'b1, 8'(k), 1'b0, 1'b0);
            if (k == 3) check("ae_after_4_writes", bus.almost_empty, 1);
            if (k == 4) check("ae_after_5_writes", bus.almost_empty, 0);
            if (k == 58) check("af_after_59_writes", bus.almost_full, 0);
            if (k == 59) check("af_after_60_writes", bus.almost_full, 1);
            if (k == 62) check("full_after_63_writes", bus.full, 0);
        end
        check("fill_full", bus.full, 1);
        check("fill_count", bus.fifo_counter, 64);

        // Write at full: overflow, sticky, then cleared.
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        check("ovf_set", bus.overflow, 1);
        check("ovf_count", bus.fifo_counter, 64);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("ovf_sticky", bus.overflow, 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_cleared", bus.overflow, 0);

        // Simultaneous read and write at full.
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        check("rw_at_full_count", bus.fifo_counter, 64);

        // Drain: expects 1..63 then 0xAA via the scoreboard.
        for (int k = 0; k < 64; k++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("drain_count", bus.fifo_counter, 0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("udf_set", bus.underflow, 1);
        check("udf_count", bus.fifo_counter, 0);
        check("udf_no_valid", bus.rd_valid, 0);
        // Clear and a new underflow in the same cycle: set wins.
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        check("udf_set_wins", bus.underflow, 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("udf_cleared", bus.underflow, 0);

        // Empty with read and write together: only the write is taken.
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        check("empty_rw_count", bus.fifo_counter, 1);
        check("empty_rw_no_valid", bus.rd_valid, 0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);

        // Wrap-around: three rounds of 40 in / 40 out.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 40; i++) cycle(1'b1, 8'(r * 40 + i), 1'b0, 1'b0);
            check("wrap_full_round", bus.fifo_counter, 40);
            for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
            check("wrap_round_empty", bus.fifo_counter, 0);
        end

        // Asynchronous reset mid-operation with count 10.
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        check("pre_reset_count", bus.fifo_counter, 10);
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        bus.data_in = 8'hEE;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_count", bus.fifo_counter, 0);
        check("async_rst_empty", bus.empty, 1);
        check("async_rst_rd_valid", bus.rd_valid, 0);
        model_q.delete();
        exp_q.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // First write after reset goes to location 0 and reads back.
        cycle(1'b1, 8'h5C, 1'b0, 1'b0);
        cycle(1'b1, 8'hC5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
